// File: rtl/divider_pkg.sv
// Shared types and constants for the signed 8-bit sequential divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_pkg;

    localparam int DATA_W    = 8;
    localparam int DIV_STEPS = 8;
    localparam int STEP_W    = $clog2(DIV_STEPS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        FIX,
        DONE
    } state_t;

    // Unsigned magnitude of a two's complement value; -128 maps to 128.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/divider_hex_driver.sv
// Multiplexed 4-digit hex display: scan prescaler, digit select, segment decode.
// Latency: segments follow qval_i/rval_i combinationally; the digit advances every 2**REFRESH_BITS cycles.
// Backpressure: none; the scan free-runs and never stalls the divider.
module hex_driver #(
    parameter int REFRESH_BITS = 16
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] qval_i,
    input  logic [7:0] rval_i,
    output logic [3:0] hex_grid_o,
    output logic [7:0] hex_seg_o
);

    logic [REFRESH_BITS-1:0] pre_q;
    logic [1:0]              digit_q;
    logic [3:0]              nibble;

    // Prescaler wraps naturally; the digit steps 0..3 once per full prescaler period.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pre_q   <= '0;
            digit_q <= 2'd0;
        end else begin
            pre_q <= pre_q + 1'b1;
            if (&pre_q) begin
                digit_q <= digit_q + 2'd1;
            end
        end
    end

    // Digit 0/1 show the remainder lo/hi nibble, digit 2/3 the quotient lo/hi nibble.
    always_comb begin
        nibble = rval_i[3:0];
        case (digit_q)
            2'd0: nibble = rval_i[3:0];
            2'd1: nibble = rval_i[7:4];
            2'd2: nibble = qval_i[3:0];
            2'd3: nibble = qval_i[7:4];
            default: nibble = rval_i[3:0];
        endcase
    end

    assign hex_grid_o = ~(4'b0001 << digit_q);

    // Active-low g..a segment patterns; the decimal point stays dark.
    always_comb begin
        hex_seg_o = 8'hC0;
        case (nibble)
            4'h0: hex_seg_o = 8'hC0;
            4'h1: hex_seg_o = 8'hF9;
            4'h2: hex_seg_o = 8'hA4;
            4'h3: hex_seg_o = 8'hB0;
            4'h4: hex_seg_o = 8'h99;
            4'h5: hex_seg_o = 8'h92;
            4'h6: hex_seg_o = 8'h82;
            4'h7: hex_seg_o = 8'hF8;
            4'h8: hex_seg_o = 8'h80;
            4'h9: hex_seg_o = 8'h90;
            4'hA: hex_seg_o = 8'h88;
            4'hB: hex_seg_o = 8'h83;
            4'hC: hex_seg_o = 8'hC6;
            4'hD: hex_seg_o = 8'hA1;
            4'hE: hex_seg_o = 8'h86;
            4'hF: hex_seg_o = 8'h8E;
            default: hex_seg_o = 8'hC0;
        endcase
    end

endmodule

// File: rtl/divider.sv
// Signed 8-bit restoring divider with held divisor, flags and hex display.
// Latency: results 10 edges after Run is sampled in IDLE (1 edge for divide-by-zero).
// Backpressure: Run is a level request; results hold in DONE until Run drops.
module divider
    import divider_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [DATA_W-1:0] SW,
    input  logic              Load_Clear,
    input  logic              Run,
    output logic [DATA_W-1:0] Qval,
    output logic [DATA_W-1:0] Rval,
    output logic [DATA_W-1:0] Dval,
    output logic              Done,
    output logic              Div0,
    output logic              Ovf,
    output logic [3:0]        hex_grid,
    output logic [7:0]        hex_seg
);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;     // raw captured dividend
    logic [DATA_W-1:0] sh_q, sh_d;       // dividend magnitude, shifted out MSB-first
    logic [DATA_W-1:0] dmag_q, dmag_d;   // divisor magnitude
    logic [DATA_W-1:0] rem_q, rem_d;     // partial remainder magnitude
    logic [DATA_W-1:0] quo_q, quo_d;     // quotient magnitude
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [DATA_W-1:0] qval_q, qval_d;
    logic [DATA_W-1:0] rval_q, rval_d;
    logic [DATA_W-1:0] dval_q, dval_d;
    logic              done_q, done_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;

    assign shifted = {rem_q, sh_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dmag_q};

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            dvd_q   <= '0;
            sh_q    <= '0;
            dmag_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            qval_q  <= '0;
            rval_q  <= '0;
            dval_q  <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dvd_q   <= dvd_d;
            sh_q    <= sh_d;
            dmag_q  <= dmag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            qval_q  <= qval_d;
            rval_q  <= rval_d;
            dval_q  <= dval_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath control; Load_Clear overrides everything.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        dvd_d   = dvd_q;
        sh_d    = sh_q;
        dmag_d  = dmag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        qval_d  = qval_q;
        rval_d  = rval_q;
        dval_d  = dval_q;
        done_d  = done_q;
        div0_d  = div0_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (Run) begin
                    dvd_d   = SW;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sh_d   = mag(dvd_q);
                dmag_d = mag(dval_q);
                qneg_d = dvd_q[DATA_W-1] ^ dval_q[DATA_W-1];
                rneg_d = dvd_q[DATA_W-1];
                rem_d  = '0;
                quo_d  = '0;
                step_d = '0;
                if (dval_q == '0) begin
                    qval_d  = '1;
                    rval_d  = dvd_q;
                    div0_d  = 1'b1;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                sh_d = {sh_q[DATA_W-2:0], 1'b0};
                if (!trial[DATA_W]) begin
                    rem_d = trial[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                if (step_q == STEP_W'(DIV_STEPS - 1)) begin
                    step_d  = '0;
                    state_d = FIX;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            FIX: begin
                qval_d  = qneg_q ? (~quo_q + 1'b1) : quo_q;
                rval_d  = rneg_q ? (~rem_q + 1'b1) : rem_q;
                ovf_d   = (dvd_q == 8'h80) && (dval_q == 8'hFF);
                div0_d  = 1'b0;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!Run) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (Load_Clear) begin
            state_d = IDLE;
            step_d  = '0;
            dval_d  = SW;
            qval_d  = '0;
            rval_d  = '0;
            done_d  = 1'b0;
            div0_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    assign Qval = qval_q;
    assign Rval = rval_q;
    assign Dval = dval_q;
    assign Done = done_q;
    assign Div0 = div0_q;
    assign Ovf  = ovf_q;

    hex_driver #(
        .REFRESH_BITS(REFRESH_BITS)
    ) u_hex (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .qval_i    (qval_q),
        .rval_i    (rval_q),
        .hex_grid_o(hex_grid),
        .hex_seg_o (hex_seg)
    );

endmodule
